// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package mips_pkg;

  typedef enum logic [2:0] {
    IDLE, CLEAR, HDR, DATA, CHK, DONE, ERR
  } loader_state_t;

  localparam int LDR_HDR_BYTES  = 2;
  localparam int LDR_WORD_BYTES = 4;

endpackage

// File: rtl/imem_loader_packer.sv
// Packs an MSB-first byte stream into 32-bit words; word_valid pulses the
// cycle after the fourth byte of a word is taken.
module byte_word_packer
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic [1:0]  byte_cnt,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] sh_q, sh_d;
  logic        wv_q, wv_d;

  // clear wins over a byte arriving in the same cycle
  always_comb begin
    cnt_d = cnt_q;
    sh_d  = sh_q;
    wv_d  = 1'b0;
    if (clear) begin
      cnt_d = '0;
      sh_d  = '0;
    end else if (in_valid) begin
      sh_d  = {sh_q[23:0], in_byte};
      cnt_d = cnt_q + 2'd1;
      wv_d  = (cnt_q == 2'(LDR_WORD_BYTES - 1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      sh_q  <= '0;
      wv_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sh_q  <= sh_d;
      wv_q  <= wv_d;
    end
  end

  assign byte_cnt   = cnt_q;
  assign word       = sh_q;
  assign word_valid = wv_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: clears instruction memory, loads a length-prefixed, XOR-checked
// program from a byte stream and releases the core only after a good load.
module imem_loader
  import mips_pkg::*;
#(
  parameter int IMEM_DEPTH = 512,
  parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] clr_q, clr_d;
  logic [ADDR_W:0]   n_q, n_d, wl_q, wl_d;
  logic [31:0]       xor_q, xor_d;

  logic        xfer, pk_clr, start_load, hdr_last, hdr_bad, data_wr, chk_last, clr_last;
  logic [1:0]  byte_cnt;
  logic [31:0] word, chk_word;
  logic        word_valid;
  logic [15:0] hdr_n;

  assign xfer       = rx_valid & rx_ready;
  // the final header/checksum byte is still on rx_data, not yet in the packer
  assign hdr_n      = {word[7:0], rx_data};
  assign chk_word   = {word[23:0], rx_data};
  assign start_load = load_start & (state_q inside {IDLE, DONE, ERR});
  assign hdr_last   = (state_q == HDR) & xfer & (byte_cnt == 2'(LDR_HDR_BYTES - 1));
  assign hdr_bad    = (hdr_n == '0) || (hdr_n > 16'(IMEM_DEPTH));
  assign data_wr    = (state_q == DATA) & word_valid;
  assign chk_last   = (state_q == CHK) & xfer & (byte_cnt == 2'(LDR_WORD_BYTES - 1));
  assign clr_last   = (clr_q == ADDR_W'(IMEM_DEPTH - 1));
  assign pk_clr     = start_load | hdr_last;

  byte_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (pk_clr),
    .in_valid   (xfer),
    .in_byte    (rx_data),
    .byte_cnt   (byte_cnt),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE, ERR: if (start_load) state_d = CLEAR;
      CLEAR:           if (clr_last) state_d = HDR;
      HDR:             if (hdr_last) state_d = hdr_bad ? ERR : DATA;
      // a byte taken during the last word's write cycle is checksum byte 0
      DATA:            if (data_wr && (wl_q == n_q - 1'b1)) state_d = CHK;
      CHK:             if (chk_last) state_d = (chk_word == xor_q) ? DONE : ERR;
      default:         state_d = IDLE;
    endcase
  end

  always_comb begin
    clr_d = (state_q == CLEAR) ? clr_q + 1'b1 : '0;
    n_d   = hdr_last ? hdr_n[ADDR_W:0] : n_q;
    wl_d  = wl_q;
    xor_d = xor_q;
    if (start_load) begin
      wl_d  = '0;
      xor_d = '0;
    end else if (data_wr) begin
      wl_d  = wl_q + 1'b1;
      xor_d = xor_q ^ word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_q <= '0;
      n_q   <= '0;
      wl_q  <= '0;
      xor_q <= '0;
    end else begin
      clr_q <= clr_d;
      n_q   <= n_d;
      wl_q  <= wl_d;
      xor_q <= xor_d;
    end
  end

  always_comb begin
    rx_ready     = state_q inside {HDR, DATA, CHK};
    busy         = state_q inside {CLEAR, HDR, DATA, CHK};
    done         = (state_q == DONE);
    err          = (state_q == ERR);
    core_rst     = (state_q != DONE);
    imem_we      = (state_q == CLEAR) | data_wr;
    imem_addr    = '0;
    imem_wdata   = '0;
    words_loaded = wl_q;
    if (state_q == CLEAR) begin
      imem_addr = clr_q;
    end else if (data_wr) begin
      imem_addr  = wl_q[ADDR_W-1:0];
      imem_wdata = word;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: vector table of complete loads plus
// hand sequences for mid-load reset, reload and ignored start pulses.
module tb_imem_loader;

  localparam int DEPTH = 512;
  localparam int AW    = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_start = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          rx_ready, imem_we, core_rst, busy, done, err;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   words_loaded;

  imem_loader #(.IMEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .core_rst(core_rst),
    .busy(busy), .done(done), .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] hdr;
    int          nw;
    logic [31:0] w [3];
    logic [31:0] chkw;
    bit          body;
    int          gap;
    bit          e_done;
    bit          e_err;
    int          e_wl;
    int          e_wr;
  } vec_t;

  vec_t vt [6];
  int checks = 0;
  int errors = 0;

  // memory model, with a side port to plant stale contents
  logic [31:0]   mem [DEPTH];
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [31:0]   pre_data = '0;
  always @(posedge clk) begin
    if (pre_en)  mem[pre_addr]  <= pre_data;
    if (imem_we) mem[imem_addr] <= imem_wdata;
  end

  // write-timing monitor: each data word must land the cycle after its 4th byte
  int          cur_nw = 0;
  logic [31:0] cur_w [3];
  int bi = 0, pend_idx = 0, we_cnt = 0, wr_ok = 0, wr_bad = 0, crst_bad = 0;
  bit pend = 1'b0;
  always @(negedge clk) begin
    if (pend) begin
      if (imem_we && imem_addr == AW'(pend_idx) && imem_wdata == cur_w[pend_idx]) wr_ok++;
      else wr_bad++;
    end
    pend = 1'b0;
    if (imem_we) we_cnt++;
    if (!core_rst && !done) crst_bad++;
    if (load_start) begin
      bi = 0; wr_ok = 0; wr_bad = 0;
    end else if (rx_valid && rx_ready) begin
      if (bi >= 2 && bi < 2 + 4 * cur_nw && (bi - 2) % 4 == 3) begin
        pend = 1'b1;
        pend_idx = (bi - 2) / 4;
      end
      bi++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // pulse load_start, optionally pulse it again during CLEAR, and check the sweep
  task automatic start_load(input int again_at);
    int bad = 0;
    @(posedge clk); #1 load_start = 1'b1;
    @(posedge clk); #1 load_start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      if (!(imem_we === 1'b1 && imem_addr === AW'(i) && imem_wdata === 32'h0 &&
            busy === 1'b1 && rx_ready === 1'b0 && core_rst === 1'b1)) bad++;
      if (i == again_at)     begin @(posedge clk); #1 load_start = 1'b1; end
      if (i == again_at + 1) begin @(posedge clk); #1 load_start = 1'b0; end
    end
    chk("clear_sweep", bad, 0);
    @(negedge clk);
    chk("clear_end_we", imem_we, 1'b0);
    chk("hdr_ready", rx_ready, 1'b1);
    @(posedge clk); #1;
  endtask

  // called just after a rising edge; returns just after the accepting edge
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    rx_data = b; rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_ready && t < 40) begin @(negedge clk); t++; end
    chk("rx_ready_wait", rx_ready, 1'b1);
    @(posedge clk); #1 rx_valid = 1'b0;
  endtask

  task automatic send_prog(input int i);
    logic [7:0] q[$];
    q.push_back(vt[i].hdr[15:8]);
    q.push_back(vt[i].hdr[7:0]);
    if (vt[i].body) begin
      for (int k = 0; k < vt[i].nw; k++)
        for (int s = 3; s >= 0; s--) q.push_back(vt[i].w[k][8*s +: 8]);
      for (int s = 3; s >= 0; s--) q.push_back(vt[i].chkw[8*s +: 8]);
    end
    foreach (q[j]) begin
      send_byte(q[j]);
      if (vt[i].gap > 0) repeat ($urandom_range(0, vt[i].gap)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic run_vec(input int i, input int again_at);
    int base, t;
    cur_nw = vt[i].body ? vt[i].nw : 0;
    cur_w  = vt[i].w;
    base   = we_cnt;
    start_load(again_at);
    send_prog(i);
    t = 0;
    @(negedge clk);
    while (!(done || err) && t < 20) begin @(negedge clk); t++; end
    chk("finished", done | err, 1'b1);
    if (!vt[i].body) chk("hdr_err_latency", t, 0);
    @(posedge clk); #1;
    chk("done", done, vt[i].e_done);
    chk("err", err, vt[i].e_err);
    chk("core_rst", core_rst, !vt[i].e_done);
    chk("busy", busy, 1'b0);
    chk("words_loaded", words_loaded, vt[i].e_wl);
    chk("write_count", we_cnt - base, vt[i].e_wr);
    chk("timed_writes", wr_ok, cur_nw);
    chk("late_or_bad_writes", wr_bad, 0);
    for (int k = 0; k < cur_nw; k++) chk("mem_word", mem[k], vt[i].w[k]);
    chk("mem_cleared_tail", mem[vt[i].nw], 32'h0);
  endtask

  initial begin
    int crst_base;
    vt[0] = '{16'h0003, 3, '{32'h20010001, 32'h20020002, 32'h00000000}, 32'h00030003, 1'b1, 0, 1'b1, 1'b0, 3, 515};
    vt[1] = '{16'h0003, 3, '{32'h20010001, 32'h20020002, 32'h00000000}, 32'h00030004, 1'b1, 0, 1'b0, 1'b1, 3, 515};
    vt[2] = '{16'h0000, 0, '{32'h0, 32'h0, 32'h0}, 32'h0, 1'b0, 0, 1'b0, 1'b1, 0, 512};
    vt[3] = '{16'h0201, 0, '{32'h0, 32'h0, 32'h0}, 32'h0, 1'b0, 0, 1'b0, 1'b1, 0, 512};
    vt[4] = '{16'h0003, 3, '{32'h20010001, 32'h20020002, 32'h00000000}, 32'h00030003, 1'b1, 5, 1'b1, 1'b0, 3, 515};
    vt[5] = '{16'h0001, 1, '{32'h12345678, 32'h0, 32'h0}, 32'h12345678, 1'b1, 2, 1'b1, 1'b0, 1, 513};

    #2;
    chk("rst_we", imem_we, 1'b0);
    chk("rst_addr", imem_addr, '0);
    chk("rst_wdata", imem_wdata, 32'h0);
    chk("rst_ready", rx_ready, 1'b0);
    chk("rst_core_rst", core_rst, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_words", words_loaded, '0);
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(i, -1);

    // bytes offered outside a load are not consumed
    rx_data = 8'hA5; rx_valid = 1'b1;
    repeat (3) begin @(negedge clk); chk("ready_in_done", rx_ready, 1'b0); end
    @(posedge clk); #1 rx_valid = 1'b0;

    // reset in the middle of DATA, then a clean reload
    cur_nw = 3; cur_w = vt[0].w;
    start_load(-1);
    send_byte(8'h00); send_byte(8'h03); send_byte(8'h20); send_byte(8'h01); send_byte(8'h00);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_we", imem_we, 1'b0);
    chk("mid_rst_ready", rx_ready, 1'b0);
    chk("mid_rst_core_rst", core_rst, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_words", words_loaded, '0);
    chk("mid_rst_addr", imem_addr, '0);
    @(posedge clk); #1 rst = 1'b0;
    run_vec(0, -1);

    // stale contents wiped by reload; second start pulse during CLEAR ignored
    @(posedge clk); #1 pre_en = 1'b1; pre_addr = AW'(100); pre_data = 32'hDEADBEEF;
    @(posedge clk); #1 pre_en = 1'b0;
    chk("preload", mem[100], 32'hDEADBEEF);
    crst_base = crst_bad;
    run_vec(0, 10);
    chk("reload_cleared_100", mem[100], 32'h0);
    chk("reload_core_rst_held", crst_bad - crst_base, 0);
    chk("core_rst_only_when_done", crst_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
